// File: rtl/display_pkg.sv
// Shared constants, scan-state encoding and the leading-zero mask helper
// for the multiplexed BCD display scanner.
package display_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    // Masks zero digits above the most significant nonzero one; digit 0 always stays lit.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [BCD_W*MAX_DIGITS-1:0] d,
        input int                          n
    );
        logic seen_nz;
        lz_mask = '0;
        seen_nz = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < n) begin
                if (!seen_nz && (d[i*BCD_W +: BCD_W] == '0)) begin
                    lz_mask[i] = 1'b1;
                end else begin
                    seen_nz = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/bcd_display_scan_if.sv
// Digit/segment bus between the clock core (master) and the display scanner (slave).
interface bcd_display_scan_if #(
    parameter int NUM_DIGITS = 6
);
    import display_pkg::*;

    logic                          en;
    logic [BCD_W*NUM_DIGITS-1:0]   digits_bcd;
    logic [NUM_DIGITS-1:0]         dp_in;
    logic [BCD_W-1:0]              bcd_out;
    logic                          dp_out;
    logic [NUM_DIGITS-1:0]         anode_n;
    logic                          frame_start;

    modport master (
        output en, digits_bcd, dp_in,
        input  bcd_out, dp_out, anode_n, frame_start
    );

    modport slave (
        input  en, digits_bcd, dp_in,
        output bcd_out, dp_out, anode_n, frame_start
    );

endinterface

// File: rtl/scan_slot_timer.sv
// Per-slot cycle counter: counts the blanking phase, then the lit phase,
// and flags the terminal cycle of each.
module scan_slot_timer #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_show,
    output logic o_blank_done,
    output logic o_show_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);

    generate
        if (BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_cfg_err
            $error("scan_slot_timer: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < REFRESH_DIV");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic             w_done;

    assign o_blank_done = (r_cnt == BLANK_LAST);
    assign o_show_done  = (r_cnt == SHOW_LAST);
    assign w_done       = i_show ? o_show_done : o_blank_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_run || w_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 7-segment scanner with per-frame digit double-buffering.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module bcd_display_scan
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_display_scan_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    generate
        if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS) begin : g_cfg_err
            $error("bcd_display_scan: NUM_DIGITS must be in 2..MAX_DIGITS");
        end
    endgenerate

    scan_state_t                     r_state, w_state_nx;
    logic [IDX_W-1:0]                r_idx, w_idx_nx;
    logic [NUM_DIGITS-1:0][BCD_W-1:0] r_shadow, w_shadow_nx;
    logic [NUM_DIGITS-1:0]           r_dp_sh, w_dp_sh_nx, w_mask_nx;
    logic                            w_load, w_run, w_show;
    logic                            w_blank_done, w_show_done;
    logic [BCD_W-1:0]                r_bcd;
    logic                            r_dp, r_frame_start;
    logic [NUM_DIGITS-1:0]           r_anode_n;

    assign w_run  = bus.en && (r_state != IDLE);
    assign w_show = (r_state == SHOW);

    scan_slot_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_run        (w_run),
        .i_show       (w_show),
        .o_blank_done (w_blank_done),
        .o_show_done  (w_show_done)
    );

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_load     = 1'b0;
        if (!bus.en) begin
            w_state_nx = IDLE;
            w_idx_nx   = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_nx = BLANK;
                    w_idx_nx   = '0;
                    w_load     = 1'b1;
                end
                BLANK: begin
                    if (w_blank_done) w_state_nx = SHOW;
                end
                SHOW: begin
                    if (w_show_done) begin
                        w_state_nx = BLANK;
                        if (r_idx == IDX_LAST) begin
                            w_idx_nx = '0;
                            w_load   = 1'b1;
                        end else begin
                            w_idx_nx = r_idx + 1'b1;
                        end
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    // Shadow registers only change at frame boundaries, so a frame never mixes old and new digits.
    assign w_shadow_nx = w_load ? bus.digits_bcd : r_shadow;
    assign w_dp_sh_nx  = w_load ? bus.dp_in      : r_dp_sh;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] r_mask;
    logic [MAX_DIGITS-1:0] w_lz_full;

    assign w_lz_full = lz_mask((BCD_W*MAX_DIGITS)'(bus.digits_bcd), NUM_DIGITS);
    assign w_mask_nx = w_load ? w_lz_full[NUM_DIGITS-1:0] : r_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_mask <= '0;
        else        r_mask <= w_mask_nx;
    end
`else
    assign w_mask_nx = '0;
`endif

    // Outputs are loaded from next-state values so they line up with the new state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_shadow      <= '0;
            r_dp_sh       <= '0;
            r_bcd         <= '0;
            r_dp          <= 1'b0;
            r_anode_n     <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_idx         <= w_idx_nx;
            r_shadow      <= w_shadow_nx;
            r_dp_sh       <= w_dp_sh_nx;
            r_frame_start <= w_load;
            if (w_state_nx == IDLE) begin
                r_bcd     <= '0;
                r_dp      <= 1'b0;
                r_anode_n <= '1;
            end else begin
                r_bcd     <= w_shadow_nx[w_idx_nx];
                r_dp      <= w_dp_sh_nx[w_idx_nx] & ~w_mask_nx[w_idx_nx];
                r_anode_n <= '1;
                if (w_state_nx == SHOW && !w_mask_nx[w_idx_nx]) begin
                    r_anode_n[w_idx_nx] <= 1'b0;
                end
            end
        end
    end

    assign bus.bcd_out     = r_bcd;
    assign bus.dp_out      = r_dp;
    assign bus.anode_n     = r_anode_n;
    assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan (4 digits, 8-cycle slots, 2 blank cycles):
// frame-position scoreboard plus a table of per-frame digit vectors.
module tb_bcd_display_scan;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;

    typedef struct {
        logic [3:0] anode;
        logic [3:0] bcd;
        logic       dp;
        logic       fs;
        logic       chk_data;
    } exp_t;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  exp_lit;
        logic [15:0] exp_seen;
        logic [3:0]  exp_dps;
    } vec_t;

    logic clk, clk_run, rst_n;
    int   n_checks, n_fail;

    exp_t        sb_q[$];
    logic        m_active;
    int          m_pos;
    logic [15:0] m_snap;
    logic [3:0]  m_dpsnap, m_mask;
    vec_t        tbl[6];

    bcd_display_scan_if #(.NUM_DIGITS(ND)) u_if();

    bcd_display_scan #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic load_snapshot();
        logic all_zero;
        m_snap   = u_if.digits_bcd;
        m_dpsnap = u_if.dp_in;
        m_mask   = '0;
`ifdef LEADING_ZERO_BLANK_EN
        all_zero = 1'b1;
        for (int i = ND - 1; i >= 1; i--) begin
            if (all_zero && m_snap[i*4 +: 4] == 4'h0) m_mask[i] = 1'b1;
            else all_zero = 1'b0;
        end
`else
        all_zero = 1'b0;
`endif
    endtask

    // Expected outputs after an edge, derived from the position within the frame.
    task automatic model_step(output exp_t e);
        int   slot, off;
        logic masked;
        e.anode = 4'hF; e.bcd = 4'h0; e.dp = 1'b0; e.fs = 1'b0; e.chk_data = 1'b0;
        if (!rst_n) begin
            m_active   = 1'b0;
            e.chk_data = 1'b1;
        end else if (!u_if.en) begin
            m_active = 1'b0;
        end else begin
            if (!m_active) begin
                m_active = 1'b1;
                m_pos    = 0;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
            end
            if (m_pos == 0) load_snapshot();
            slot       = m_pos / RD;
            off        = m_pos % RD;
            masked     = m_mask[slot];
            e.anode    = (off >= BC && !masked) ? ~(4'b0001 << slot) : 4'hF;
            e.bcd      = m_snap[slot*4 +: 4];
            e.dp       = m_dpsnap[slot] & ~masked;
            e.fs       = (m_pos == 0);
            e.chk_data = 1'b1;
        end
    endtask

    task automatic tick();
        exp_t e, g;
        @(posedge clk);
        model_step(e);
        sb_q.push_back(e);
        @(negedge clk);
        g = sb_q.pop_front();
        check("sb_anode_n", 32'(u_if.anode_n), 32'(g.anode));
        check("sb_frame_start", 32'(u_if.frame_start), 32'(g.fs));
        if (g.chk_data) begin
            check("sb_bcd_out", 32'(u_if.bcd_out), 32'(g.bcd));
            check("sb_dp_out", 32'(u_if.dp_out), 32'(g.dp));
        end
    endtask

    task automatic wait_fs(input string name);
        int n;
        tick();
        n = 1;
        while (u_if.frame_start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(u_if.frame_start), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_anode_n"}, 32'(u_if.anode_n), 32'hF);
        check({tag, "_bcd_out"}, 32'(u_if.bcd_out), 32'h0);
        check({tag, "_dp_out"}, 32'(u_if.dp_out), 32'h0);
        check({tag, "_frame_start"}, 32'(u_if.frame_start), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [3:0]  lit, dps;
        logic [15:0] seen;

        n_checks = 0; n_fail = 0;
        m_active = 1'b0; m_pos = 0; m_snap = '0; m_dpsnap = '0; m_mask = '0;
        clk = 1'b0; clk_run = 1'b0; rst_n = 1'b1;
        u_if.en = 1'b0; u_if.digits_bcd = '0; u_if.dp_in = '0;

        //               digits    dp       lit      seen      dp seen while lit
        tbl[0] = '{16'h1234, 4'b0000, 4'b1111, 16'h1234, 4'b0000};
        tbl[1] = '{16'h5678, 4'b0100, 4'b1111, 16'h5678, 4'b0100};
        tbl[5] = '{16'hFFFF, 4'b1111, 4'b1111, 16'hFFFF, 4'b1111};
`ifdef LEADING_ZERO_BLANK_EN
        tbl[2] = '{16'h0107, 4'b0000, 4'b0111, 16'h0107, 4'b0000};
        tbl[3] = '{16'h0000, 4'b1001, 4'b0001, 16'h0000, 4'b0001};
        tbl[4] = '{16'h00A0, 4'b0010, 4'b0011, 16'h00A0, 4'b0010};
`else
        tbl[2] = '{16'h0107, 4'b0000, 4'b1111, 16'h0107, 4'b0000};
        tbl[3] = '{16'h0000, 4'b1001, 4'b1111, 16'h0000, 4'b1001};
        tbl[4] = '{16'h00A0, 4'b0010, 4'b1111, 16'h00A0, 4'b0010};
`endif

        // Asynchronous reset with the clock stopped
        #5 rst_n = 1'b0;
        #1 check_reset_outputs("rst_noclk");
        #4 rst_n = 1'b1;
        clk_run = 1'b1;
        repeat (2) tick();

        // First frame and frame period
        u_if.digits_bcd = 16'h1234;
        u_if.en = 1'b1;
        wait_fs("fs_first");
        check("first_bcd", 32'(u_if.bcd_out), 32'h4);
        check("first_anode", 32'(u_if.anode_n), 32'hF);
        n = 0;
        do begin
            tick();
            n++;
        end while (u_if.frame_start !== 1'b1 && n < 40);
        check("frame_period", 32'(n), 32'(FRAME));

        // Mid-frame input change is held off until the next frame
        repeat (11) tick();
        u_if.digits_bcd = 16'h5678;
        repeat (7) tick();
        check("midframe_digit2_bcd", 32'(u_if.bcd_out), 32'h2);
        check("midframe_digit2_anode", 32'(u_if.anode_n), 32'hB);
        wait_fs("fs_after_change");
        check("new_frame_bcd", 32'(u_if.bcd_out), 32'h8);

        // Disable during digit 2 SHOW, then re-enable
        repeat (19) tick();
        u_if.en = 1'b0;
        tick();
        check("disable_anode", 32'(u_if.anode_n), 32'hF);
        repeat (2) tick();
        u_if.en = 1'b1;
        tick();
        check("reenable_fs", 32'(u_if.frame_start), 32'h1);
        check("reenable_bcd", 32'(u_if.bcd_out), 32'h8);

        // Table of per-frame digit vectors
        for (int v = 0; v < 6; v++) begin
            u_if.digits_bcd = tbl[v].digits;
            u_if.dp_in      = tbl[v].dp;
            wait_fs($sformatf("vec%0d_fs", v));
            lit = '0; seen = '0; dps = '0;
            for (int c = 0; c < FRAME; c++) begin
                if (c > 0) tick();
                for (int d = 0; d < ND; d++) begin
                    if (u_if.anode_n[d] == 1'b0) begin
                        lit[d] = 1'b1;
                        seen[d*4 +: 4] = u_if.bcd_out;
                        if (u_if.dp_out) dps[d] = 1'b1;
                    end
                end
            end
            check($sformatf("vec%0d_lit", v), 32'(lit), 32'(tbl[v].exp_lit));
            check($sformatf("vec%0d_seen", v), 32'(seen), 32'(tbl[v].exp_seen));
            check($sformatf("vec%0d_dp", v), 32'(dps), 32'(tbl[v].exp_dps));
        end

        // dp on digit 2, then asynchronous reset mid-SHOW
        u_if.digits_bcd = 16'h1234;
        u_if.dp_in      = 4'b0100;
        wait_fs("fs_dp_frame");
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_midshow");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_fs", 32'(u_if.frame_start), 32'h1);
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Time-multiplexed scanner for the clock's multi-digit 7-segment display.
- Takes all BCD digits in parallel, presents one digit at a time on bcd_out to the per-digit BCD-to-segment decoder, and drives the common anode of the matching digit.
- Inserts a blanking interval between digits to suppress ghosting.
- Double-buffers digit values per frame so a display frame never shows mixed old and new time.

Parameters:
- NUM_DIGITS, 6, number of multiplexed digits (>=2).
- REFRESH_DIV, 100000, clock cycles per digit slot, including blanking.
- BLANK_CYCLES, 16, all-anodes-off cycles at the start of each slot. Constraint: 1 <= BLANK_CYCLES < REFRESH_DIV, elaboration-time check.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  scan enable; 0 blanks the display.
- digits_bcd  input  4*NUM_DIGITS  digit i = bits [4i+3:4i]; digit 0 is least significant (rightmost).
- dp_in  input  NUM_DIGITS  decimal point request per digit.
- bcd_out  output  4  current digit value, to the segment decoder.
- dp_out  output  1  decimal point for the current digit.
- anode_n  output  NUM_DIGITS  active-low digit enables.
- frame_start  output  1  one-cycle pulse when a new frame begins.

Behaviour:
- All outputs are registered. Reset is asynchronous and active-low; clk is the only clock.
- Reset values (take effect immediately, no clock edge needed):
  - state=IDLE, idx=0, cnt=0.
  - shadow digits and dp = 0.
  - bcd_out=0, dp_out=0, anode_n=all 1, frame_start=0.
- IDLE:
  - anode_n=all 1.
  - If en=1: next state BLANK, idx=0, cnt=0, shadow<=digits_bcd/dp_in, frame_start=1 for one cycle.
- BLANK:
  - anode_n=all 1; bcd_out/dp_out = shadow[idx], so data settles before the anode turns on.
  - cnt counts 0..BLANK_CYCLES-1. At terminal count: next state SHOW, cnt=0.
- SHOW:
  - anode_n[idx]=0, all others 1.
  - cnt counts 0..REFRESH_DIV-BLANK_CYCLES-1. At terminal count: next state BLANK, cnt=0.
  - If idx==NUM_DIGITS-1: idx wraps to 0, shadow reloads, frame_start pulses. Otherwise idx+1.
- Timing:
  - Slot length is exactly REFRESH_DIV cycles.
  - Frame length is NUM_DIGITS*REFRESH_DIV cycles.
  - frame_start is asserted in the same cycle the shadow update becomes visible.
- en=0 in any state: next edge state=IDLE, anode_n=all 1, cnt=0, idx=0. Re-enabling always restarts at digit 0 with a fresh frame_start.
- Input changes mid-frame are ignored until the next frame boundary (shadow only).
- Values 10..15 pass through unmodified; the decoder owns their glyphs.
- Width rules:
  - cnt width = clog2(REFRESH_DIV).
  - idx width = clog2(NUM_DIGITS).
  - idx never reaches values >= NUM_DIGITS.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - At each shadow load, compute a blank mask over the shadow digits. Starting from digit NUM_DIGITS-1 downward, every digit equal to 0 that precedes the first nonzero digit is masked.
  - Digit 0 is never masked.
  - A masked digit keeps anode_n high during its SHOW phase; bcd_out is still driven; slot timing is unchanged.
  - A masked digit's dp is also suppressed.
- Undefined: no masking; all digits are lit in their SHOW phase.

Decomposition:
- Shared package display_pkg holds:
  - BCD_W=4 constant.
  - Scan state enum {IDLE, BLANK, SHOW}.
  - Leading-zero mask function, used only under the macro.
- One natural sub-module: scan_slot_timer. It is the cnt counter with phase-terminal flags (blank_done, show_done), parameterised by REFRESH_DIV/BLANK_CYCLES.
- Top level holds the FSM, idx, shadow and output registers.

Test Plan (bench uses NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2):
1. Assert rst_n=0 with clk stopped -> anode_n=4'b1111, bcd_out=0, dp_out=0, frame_start=0 immediately.
2. en=1, digits_bcd=16'h1234 -> frame_start high for one cycle. Then anode_n=1111 for 2 cycles, then 4'b1110 with bcd_out=4 for 6 cycles, then 2 blank cycles, then 4'b1101 with bcd_out=3, and so on through digit 3 (value 1). frame_start repeats every 32 cycles.
3. Change digits_bcd to 16'h5678 during digit-1 SHOW -> digits 2 and 3 still show 2 and 1. The next frame shows 8,7,6,5, and frame_start coincides with the first new value.
4. Deassert en mid-SHOW of digit 2 -> anode_n=1111 at the next edge, state IDLE. Re-assert en -> frame_start pulses and scan restarts at digit 0.
5. With LEADING_ZERO_BLANK_EN defined:
   - digits 16'h0107 -> digit 3 never lit, digits 2..0 lit.
   - digits 16'h0000 -> only digit 0 lit, showing 0.
   - Same stimulus without the macro -> all four digits lit.
6. dp_in=4'b0100 -> dp_out=1 only while idx=2, including its blank phase. Then assert rst_n=0 mid-SHOW -> all outputs return to reset values asynchronously.
